// File: rtl/fb_arbiter_ctrl.sv
// Double-buffered framebuffer controller: queues engine pixel writes, arbitrates
// one RAM port between display reads and queued writes, and swaps buffers at vsync.
module fb_arbiter_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        pix_we,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [7:0]  pix_color,
    output logic        pix_ready,
    input  logic        frame_done,
    output logic        frame_start,
    output logic        buffer_using,
    input  logic        vga_re,
    input  logic [9:0]  vga_x,
    input  logic [9:0]  vga_y,
    output logic [7:0]  vga_data,
    output logic        vga_valid,
    output logic        frame_overrun,
    output logic [17:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [1:0]  fsm_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAW, DRAIN, WAIT_VS} state_t;

    state_t        state, state_nx;
    logic [24:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [24:0]   head;
    logic          in_range, push, pop;
    logic          prev_fclk, tick;
    logic          writes_idle;
    logic          start_c, overrun_c, swap_c;
    logic [1:0]    rd_pipe;

    // FIFO entry layout: {x[8:0], y[7:0], color[7:0]}
    assign head      = fifo_mem[rd_ptr];
    assign pix_ready = (count != FULL_CNT);
    assign in_range  = (pix_x < 10'd320) && (pix_y < 10'd240);
    assign push      = pix_we && pix_ready && in_range;
    assign pop       = !vga_re && (count != '0);
    assign tick      = frame_clk && !prev_fclk;
    assign writes_idle = (count == '0) && !mem_we;
    assign fsm_state = state;

    always_ff @(posedge Clk) begin
        if (push) fifo_mem[wr_ptr] <= {pix_x[8:0], pix_y[7:0], pix_color};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Display reads always win the RAM port; the write buffer index is taken at pop time.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (vga_re) begin
            mem_addr  <= {buffer_using, vga_y[7:0], vga_x[8:0]};
            mem_we    <= 1'b0;
        end else if (pop) begin
            mem_addr  <= {~buffer_using, head[15:8], head[24:16]};
            mem_we    <= 1'b1;
            mem_wdata <= head[7:0];
        end else begin
            mem_we    <= 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_pipe   <= '0;
            vga_valid <= 1'b0;
            vga_data  <= '0;
        end else begin
            rd_pipe   <= {rd_pipe[0], vga_re};
            vga_valid <= rd_pipe[1];
            if (rd_pipe[1]) vga_data <= mem_rdata;
        end
    end

    always_comb begin
        state_nx  = state;
        start_c   = 1'b0;
        overrun_c = 1'b0;
        swap_c    = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    start_c  = 1'b1;
                    state_nx = DRAW;
                end
            end
            DRAW: begin
                if (tick)       overrun_c = 1'b1;
                if (frame_done) state_nx  = DRAIN;
            end
            DRAIN: begin
                if (tick)        overrun_c = 1'b1;
                if (writes_idle) state_nx  = WAIT_VS;
            end
            WAIT_VS: begin
                // A straggling write holds off the swap until the next tick.
                if (tick && writes_idle) begin
                    swap_c   = 1'b1;
                    start_c  = 1'b1;
                    state_nx = DRAW;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            prev_fclk     <= 1'b1;
            buffer_using  <= 1'b0;
            frame_start   <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            state         <= state_nx;
            prev_fclk     <= frame_clk;
            frame_start   <= start_c;
            frame_overrun <= overrun_c;
            if (swap_c) buffer_using <= ~buffer_using;
        end
    end

endmodule

// File: tb/tb_fb_arbiter_ctrl.sv
// Scoreboard bench for fb_arbiter_ctrl with a behavioural 1-cycle-latency RAM.
module tb_fb_arbiter_ctrl;

    logic        clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic        pix_we;
    logic [9:0]  pix_x, pix_y;
    logic [7:0]  pix_color;
    logic        pix_ready;
    logic        frame_done;
    logic        frame_start;
    logic        buffer_using;
    logic        vga_re;
    logic [9:0]  vga_x, vga_y;
    logic [7:0]  vga_data;
    logic        vga_valid;
    logic        frame_overrun;
    logic [17:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [1:0]  fsm_state;

    localparam logic [1:0] S_IDLE = 2'd0, S_DRAW = 2'd1, S_WAIT_VS = 2'd3;

    fb_arbiter_ctrl #(.FIFO_DEPTH(4)) dut (
        .Clk(clk), .Reset(Reset), .frame_clk(frame_clk),
        .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .pix_ready(pix_ready), .frame_done(frame_done), .frame_start(frame_start),
        .buffer_using(buffer_using), .vga_re(vga_re), .vga_x(vga_x), .vga_y(vga_y),
        .vga_data(vga_data), .vga_valid(vga_valid), .frame_overrun(frame_overrun),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fsm_state(fsm_state)
    );

    // clock / reset-free infrastructure
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ram [0:262143];
    initial for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // scoreboard queues: writes {addr, data}; reads {cycle, data}
    logic [25:0] exp_wr_q[$];
    logic [39:0] exp_rd_q[$];
    int wr_seen = 0;
    int start_cnt = 0;
    int ovr_cnt = 0;

    always @(negedge clk) begin
        if (frame_start)   start_cnt++;
        if (frame_overrun) ovr_cnt++;
        if (mem_we) begin
            wr_seen++;
            if (exp_wr_q.size() == 0) begin
                check("unexpected_write", {6'd0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
            end else begin
                logic [25:0] e;
                e = exp_wr_q.pop_front();
                check("write_addr", {14'd0, mem_addr}, {14'd0, e[25:8]});
                check("write_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
            end
        end
        if (vga_valid) begin
            if (exp_rd_q.size() == 0) begin
                check("unexpected_read", {24'd0, vga_data}, 32'hFFFF_FFFF);
            end else begin
                logic [39:0] r;
                r = exp_rd_q.pop_front();
                check("read_data", {24'd0, vga_data}, {24'd0, r[7:0]});
                check("read_latency_cycle", cyc, r[39:8]);
            end
        end
    end

    // driver tasks (called at a negedge; DUT samples at the next posedge)
    task automatic drive_pix(input logic [9:0] x, input logic [9:0] y, input logic [7:0] c);
        pix_we = 1'b1; pix_x = x; pix_y = y; pix_color = c;
    endtask

    task automatic expect_write(input logic bufsel, input logic [9:0] x, input logic [9:0] y,
                                input logic [7:0] c);
        exp_wr_q.push_back({bufsel, y[7:0], x[8:0], c});
    endtask

    task automatic issue_read(input logic [9:0] x, input logic [9:0] y, input logic [7:0] d);
        vga_re = 1'b1; vga_x = x; vga_y = y;
        exp_rd_q.push_back({32'(cyc + 3), d});
    endtask

    task automatic frame_tick();
        frame_clk = 1'b0;
        repeat (2) @(negedge clk);
        frame_clk = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; frame_clk = 1'b1; pix_we = 1'b0; pix_x = '0; pix_y = '0;
        pix_color = '0; frame_done = 1'b0; vga_re = 1'b0; vga_x = '0; vga_y = '0;
        repeat (3) @(negedge clk);

        check("rst_pix_ready", {31'd0, pix_ready}, 32'd1);
        check("rst_buffer_using", {31'd0, buffer_using}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {14'd0, mem_addr}, 32'd0);
        check("rst_frame_start", {31'd0, frame_start}, 32'd0);
        check("rst_vga_valid", {31'd0, vga_valid}, 32'd0);
        check("rst_state", {30'd0, fsm_state}, {30'd0, S_IDLE});

        // frame_clk held high through reset release: no tick
        Reset = 1'b0;
        repeat (3) @(negedge clk);
        check("no_tick_after_reset", start_cnt, 0);
        check("still_idle", {30'd0, fsm_state}, {30'd0, S_IDLE});
        frame_tick();
        check("first_frame_start", {31'd0, frame_start}, 32'd1);
        repeat (2) @(negedge clk);
        check("frame_start_count_1", start_cnt, 1);
        check("buffer_after_start", {31'd0, buffer_using}, 32'd0);
        check("state_draw", {30'd0, fsm_state}, {30'd0, S_DRAW});

        // single pixel write into draw buffer 1
        drive_pix(10'd100, 10'd50, 8'h2C);
        expect_write(1'b1, 10'd100, 10'd50, 8'h2C);
        @(negedge clk);
        pix_we = 1'b0;
        check("mem_we_not_yet", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        check("mem_we_after_pop", {31'd0, mem_we}, 32'd1);
        check("mem_addr_pixel", {14'd0, mem_addr}, {14'd0, 1'b1, 8'd50, 9'd100});
        @(negedge clk);
        check("mem_we_one_cycle", {31'd0, mem_we}, 32'd0);

        // six reads back-to-back while pushing five pixels into a 4-deep FIFO
        for (int k = 0; k < 6; k++) begin
            if (k == 4) check("pix_ready_full", {31'd0, pix_ready}, 32'd0);
            if (k >= 1) check("no_write_during_read", {31'd0, mem_we}, 32'd0);
            issue_read(10'(k), 10'd0, 8'h00);
            if (k < 5) drive_pix(10'(10 + k), 10'(20 + k), 8'(8'h11 * (k + 1)));
            else pix_we = 1'b0;
            if (k < 4) expect_write(1'b1, 10'(10 + k), 10'(20 + k), 8'(8'h11 * (k + 1)));
            @(negedge clk);
        end
        vga_re = 1'b0; pix_we = 1'b0;
        check("no_write_last_read", {31'd0, mem_we}, 32'd0);
        repeat (8) @(negedge clk);
        check("writes_drained", exp_wr_q.size(), 0);
        check("write_count_5", wr_seen, 5);

        // frame done, drain, swap on the next tick
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        repeat (3) @(negedge clk);
        check("state_wait_vs", {30'd0, fsm_state}, {30'd0, S_WAIT_VS});
        frame_tick();
        check("swap_frame_start", {31'd0, frame_start}, 32'd1);
        check("swap_buffer_using", {31'd0, buffer_using}, 32'd1);
        @(negedge clk);
        check("frame_start_pulse_end", {31'd0, frame_start}, 32'd0);
        check("state_draw_2", {30'd0, fsm_state}, {30'd0, S_DRAW});
        issue_read(10'd100, 10'd50, 8'h2C);
        @(negedge clk);
        issue_read(10'd12, 10'd22, 8'h33);
        @(negedge clk);
        vga_re = 1'b0;
        repeat (5) @(negedge clk);
        check("reads_done", exp_rd_q.size(), 0);
        check("frame_start_count_2", start_cnt, 2);

        // tick while still drawing: overrun, no swap
        frame_tick();
        check("overrun_pulse", {31'd0, frame_overrun}, 32'd1);
        check("overrun_no_start", {31'd0, frame_start}, 32'd0);
        check("overrun_no_swap", {31'd0, buffer_using}, 32'd1);
        @(negedge clk);
        check("overrun_pulse_end", {31'd0, frame_overrun}, 32'd0);
        check("overrun_state_draw", {30'd0, fsm_state}, {30'd0, S_DRAW});

        // out-of-range pixels are dropped
        drive_pix(10'd320, 10'd0, 8'hAA);
        @(negedge clk);
        check("oor_x_ready", {31'd0, pix_ready}, 32'd1);
        drive_pix(10'd0, 10'd240, 8'hBB);
        @(negedge clk);
        pix_we = 1'b0;
        check("oor_y_ready", {31'd0, pix_ready}, 32'd1);
        repeat (4) @(negedge clk);
        check("oor_no_write", wr_seen, 5);

        // reset mid-frame discards queued pixels
        issue_read(10'd0, 10'd0, 8'h00);
        void'(exp_rd_q.pop_back());
        drive_pix(10'd1, 10'd1, 8'h01);
        @(negedge clk);
        issue_read(10'd0, 10'd0, 8'h00);
        void'(exp_rd_q.pop_back());
        drive_pix(10'd2, 10'd2, 8'h02);
        @(negedge clk);
        vga_re = 1'b0; pix_we = 1'b0; Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        check("post_reset_pix_ready", {31'd0, pix_ready}, 32'd1);
        @(negedge clk);
        check("post_reset_pix_ready_2", {31'd0, pix_ready}, 32'd1);
        check("post_reset_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
        check("post_reset_buffer", {31'd0, buffer_using}, 32'd0);
        repeat (5) @(negedge clk);
        check("reset_discards_writes", wr_seen, 5);
        check("final_wr_queue", exp_wr_q.size(), 0);
        check("final_rd_queue", exp_rd_q.size(), 0);
        check("final_start_count", start_cnt, 2);
        check("final_overrun_count", ovr_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_arbiter_ctrl.md
FB_ARBITER_CTRL -- requirements
Module: fb_arbiter_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning pixel write FIFO entries (power of two, at least 2).
REQ-002 SHALL have port Clk  in  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port Reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port frame_clk  in  1  vertical-sync-rate level signal; its rising edge is the frame tick.
REQ-005 SHALL have ports pix_we in 1, pix_x in 10, pix_y in 10, pix_color in 8: drawing engine pixel write request.
REQ-006 SHALL have port pix_ready  out  1  FIFO not full; combinational from the registered FIFO count.
REQ-007 SHALL have port frame_done  in  1  single-cycle pulse from the engine after its last pixel is issued.
REQ-008 SHALL have port frame_start  out  1  single-cycle pulse commanding the engine to draw a frame.
REQ-009 SHALL have port buffer_using  out  1  index of the buffer being displayed; the engine draws into ~buffer_using.
REQ-010 SHALL have ports vga_re in 1, vga_x in 10, vga_y in 10: display read request; vga_data out 8 and vga_valid out 1 return the read.
REQ-011 SHALL have port frame_overrun  out  1  single-cycle pulse when a frame tick arrives before drawing completes.
REQ-012 SHALL have ports mem_addr out 18, mem_we out 1, mem_wdata out 8, mem_rdata in 8: synchronous single-port RAM with 1-cycle read latency.

Function
REQ-013 SHALL form addresses as {buffer bit, y[7:0], x[8:0]}; reads use buffer_using, writes use ~buffer_using as latched when the entry is popped.
REQ-014 SHALL push {x[8:0], y[7:0], color} when pix_we && pix_ready && x<320 && y<240; out-of-range writes are dropped and pix_ready is unaffected.
REQ-015 SHALL ignore pix_we while full; push and pop in the same cycle SHALL leave the count unchanged.
REQ-016 SHALL arbitrate each cycle with strict priority: vga_re wins; otherwise pop one FIFO entry if non-empty; otherwise leave the RAM idle.
REQ-017 SHALL register mem_addr, mem_we and mem_wdata; a pop in cycle N SHALL produce mem_we=1 for exactly cycle N+1.
REQ-018 SHALL assert vga_valid exactly 2 cycles after vga_re is sampled high, with vga_data = mem_rdata; mem_we SHALL be 0 during the read.
REQ-019 SHALL detect the frame tick as frame_clk high with the registered previous frame_clk low.
REQ-020 SHALL implement FSM states IDLE, DRAW, DRAIN, WAIT_VS.
REQ-021 IDLE: on a tick, SHALL pulse frame_start without swapping and go to DRAW.
REQ-022 DRAW: frame_done SHALL move the FSM to DRAIN; a tick SHALL pulse frame_overrun and stay in DRAW with no swap.
REQ-023 DRAIN: when the FIFO is empty and registered mem_we=0, SHALL go to WAIT_VS; a tick SHALL pulse frame_overrun.
REQ-024 WAIT_VS: on a tick, SHALL toggle buffer_using and pulse frame_start in the same cycle, then go to DRAW.
REQ-025 SHALL ignore frame_done outside DRAW.
REQ-026 SHALL never change buffer_using while a write to the draw buffer is queued or in flight.

Reset
REQ-027 On Reset, SHALL clear: FSM=IDLE, FIFO empty, buffer_using=0, frame_start=0, frame_overrun=0, mem_we=0, mem_addr=0, mem_wdata=0, vga_valid=0, vga_data=0.
REQ-028 On Reset, SHALL set the previous-frame_clk register to 1 so that no tick is seen while frame_clk is held high through reset.
REQ-029 Reset mid-frame SHALL discard queued pixels; pix_ready=1 in the first cycle after reset.

Verification
REQ-030 Reset release with frame_clk=1, then frame_clk 0->1 -> exactly one frame_start pulse, buffer_using=0, FSM in DRAW.
REQ-031 Push pixel (x=100, y=50, color=0x2C) with vga_re=0 and buffer_using=0 -> mem_we=1 one cycle after the pop, mem_addr={1,8'd50,9'd100}, mem_wdata=0x2C.
REQ-032 Hold vga_re for 6 cycles while pushing 5 pixels -> pix_ready=0 after 4 pushes, no mem_we during the reads, all 4 accepted writes follow in order, 5th pixel lost.
REQ-033 frame_done, FIFO drains, then a tick -> buffer_using 0->1 with a frame_start pulse in the same cycle; a later read of (100,50) returns 0x2C with vga_valid 2 cycles after vga_re.
REQ-034 Tick while in DRAW -> frame_overrun pulse, buffer_using unchanged, no frame_start.
REQ-035 Push x=320 or y=240 -> no FIFO entry and no mem_we.
